// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb_pkg
// Description : Shared definitions for the UART transmit arbiter. Holds the
//               arbiter state encoding, the legal parameter ranges and a
//               helper for sizing the grant index.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arb_pkg;

    // Arbiter state encoding
    localparam int              c_state_w      = 1;
    localparam logic [0:0]      UART_ARB_IDLE  = 1'b0;
    localparam logic [0:0]      UART_ARB_GRANT = 1'b1;

    // Legal parameter ranges
    localparam int              c_num_req_min   = 1;
    localparam int              c_num_req_max   = 16;
    localparam int              c_max_burst_min = 1;
    localparam int              c_max_burst_max = 255;

    // Width of an index into n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin pick. Searches req[] starting at
//               ptr, upward with wrap-around, and returns the first set index.
// Ports       : req   - request vector, one bit per requester
//               ptr   - search start index (must be < NUM_REQ)
//               idx   - selected index (0 when nothing is found)
//               found - high when any request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int LOG_NUM_REQ = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]     req,
    input  logic [LOG_NUM_REQ-1:0] ptr,
    output logic [LOG_NUM_REQ-1:0] idx,
    output logic                   found
);

    // One extra bit so ptr + offset cannot overflow before the wrap compare
    logic [LOG_NUM_REQ:0] w_pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        w_pos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = {1'b0, ptr} + (LOG_NUM_REQ+1)'(i);
            // Explicit wrap: NUM_REQ need not be a power of two
            if (w_pos >= (LOG_NUM_REQ+1)'(NUM_REQ)) begin
                w_pos = w_pos - (LOG_NUM_REQ+1)'(NUM_REQ);
            end
            if (!found && req[w_pos[LOG_NUM_REQ-1:0]]) begin
                found = 1'b1;
                idx   = w_pos[LOG_NUM_REQ-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Packet-granular round-robin arbiter in front of the UART TX
//               FIFO push port. A grant is held until the granted requester
//               transfers a byte marked last, or MAX_BURST bytes have been
//               transferred, so packets never interleave on the line.
// Ports       : clk_i, rst_n_i      - clock, synchronous active-low reset
//               en_i                - allow new grants
//               req_valid_i/data/last - per-requester byte stream
//               req_ready_o         - per-requester ready (one-hot or zero)
//               push_o, dat_o       - TX FIFO push strobe and byte
//               full_i              - TX FIFO registered full flag
//               gnt_o               - current / last granted index
//               busy_o              - grant held
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 16,
    parameter int LOG_NUM_REQ = idx_width(NUM_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   push_o,
    output logic [7:0]             dat_o,
    input  logic                   full_i,
    output logic [LOG_NUM_REQ-1:0] gnt_o,
    output logic                   busy_o
);

    localparam int c_beat_w = $clog2(MAX_BURST + 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------
    if (NUM_REQ < c_num_req_min || NUM_REQ > c_num_req_max) begin : g_bad_num_req
        $error("uart_tx_arb: NUM_REQ out of range 1..16");
    end
    if (MAX_BURST < c_max_burst_min || MAX_BURST > c_max_burst_max) begin : g_bad_max_burst
        $error("uart_tx_arb: MAX_BURST out of range 1..255");
    end

    logic [c_state_w-1:0]   r_state;
    logic [c_state_w-1:0]   w_state_nxt;
    logic [LOG_NUM_REQ-1:0] r_ptr;
    logic [LOG_NUM_REQ-1:0] w_ptr_nxt;
    logic [LOG_NUM_REQ-1:0] r_gnt;
    logic [LOG_NUM_REQ-1:0] w_gnt_nxt;
    logic [c_beat_w-1:0]    r_beat;
    logic [c_beat_w-1:0]    w_beat_nxt;
    logic [c_beat_w-1:0]    w_beat_inc;
    logic [LOG_NUM_REQ-1:0] w_pick_idx;
    logic                   w_pick_found;
    logic                   w_xfer;

    uart_rr_pick #(
        .NUM_REQ     (NUM_REQ),
        .LOG_NUM_REQ (LOG_NUM_REQ)
    ) u_pick (
        .req   (req_valid_i),
        .ptr   (r_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    assign w_xfer     = (r_state == UART_ARB_GRANT) & req_valid_i[r_gnt] & ~full_i;
    assign w_beat_inc = r_beat + c_beat_w'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= UART_ARB_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_beat_nxt  = r_beat;
        case (r_state)
            UART_ARB_IDLE: begin
                if (en_i && w_pick_found) begin
                    w_gnt_nxt   = w_pick_idx;
                    w_beat_nxt  = '0;
                    w_state_nxt = UART_ARB_GRANT;
                end
            end
            UART_ARB_GRANT: begin
                // Nothing moves while the FIFO is full or the requester stalls
                if (w_xfer) begin
                    w_beat_nxt = w_beat_inc;
                    // last and burst cap together still release only once
                    if (req_last_i[r_gnt] || (w_beat_inc == c_beat_w'(MAX_BURST))) begin
                        w_state_nxt = UART_ARB_IDLE;
                        if (r_gnt == LOG_NUM_REQ'(NUM_REQ - 1)) begin
                            w_ptr_nxt = '0;
                        end else begin
                            w_ptr_nxt = r_gnt + LOG_NUM_REQ'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = UART_ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: combinational through to the FIFO, no register stage
    // ------------------------------------------------------------------
    always_comb begin
        req_ready_o = '0;
        push_o      = 1'b0;
        dat_o       = 8'h00;
        if (r_state == UART_ARB_GRANT) begin
            req_ready_o[r_gnt] = ~full_i;
            push_o             = w_xfer;
            dat_o              = req_data_i[{r_gnt, 3'b000} +: 8];
        end
    end

    assign busy_o = (r_state == UART_ARB_GRANT);
    assign gnt_o  = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Self-checking bench for uart_tx_arb (4 requesters, burst 4).
//               Requesters are byte queues; the pushed stream is captured and
//               compared with a transaction-level round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    localparam int NR = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [NR-1:0] req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic          push;
    logic [7:0]    dat;
    logic          full;
    logic [1:0]    gnt;
    logic          busy;

    uart_tx_arb #(
        .NUM_REQ   (NR),
        .MAX_BURST (MB)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .push_o      (push),
        .dat_o       (dat),
        .full_i      (full),
        .gnt_o       (gnt),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Requester byte queues: {last, data}
    logic [8:0] mem [NR][64];
    int rd [NR];
    int wr [NR];

    // Captured push stream and grant starts
    int         cap_n;
    logic [1:0] cap_g [256];
    logic [7:0] cap_d [256];
    int         cap_c [256];
    int         gs_n;
    logic [1:0] gs   [64];
    int         gap  [64];

    // Model expectations
    int         exp_n;
    logic [1:0] exp_g [256];
    logic [7:0] exp_d [256];
    int         m_ptr;

    bit rand_full = 1'b0;

    task automatic add_byte(input int k, input logic [7:0] d, input bit last);
        mem[k][wr[k]] = {last, d};
        wr[k]++;
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < NR; k++) begin
            if (rd[k] < wr[k]) begin
                req_valid[k]      = 1'b1;
                req_data[k*8 +: 8] = mem[k][rd[k]][7:0];
                req_last[k]       = mem[k][rd[k]][8];
            end else begin
                req_valid[k]      = 1'b0;
                req_data[k*8 +: 8] = 8'h00;
                req_last[k]       = 1'b0;
            end
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, pop on accepted push
    task automatic step(output bit pushed, output logic [7:0] d,
                        output logic [1:0] g, output bit b);
        logic [3:0] exp_rdy;
        @(negedge clk);
        if (rand_full) full = ($urandom_range(0, 2) == 0);
        drive_reqs();
        #1;
        pushed  = push;
        d       = dat;
        g       = gnt;
        b       = busy;
        exp_rdy = (b && !full) ? (4'b0001 << g) : 4'b0000;
        n_vec++;
        if (req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL ready: got %b expected %b", req_ready, exp_rdy);
        end
        n_vec++;
        if (push !== (b && req_valid[g] && !full)) begin
            n_err++;
            $display("FAIL push_rule: got %b busy %b valid %b full %b", push, b, req_valid[g], full);
        end
        @(posedge clk);
        if (pushed) rd[g]++;
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NR; k++) if (rd[k] < wr[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_capture(input int maxcyc, input bit init_busy);
        bit p, b, prevb, done;
        logic [7:0] d;
        logic [1:0] g;
        int cyc, gapc;
        cap_n = 0; gs_n = 0; cyc = 0; gapc = 0;
        prevb = init_busy; done = 1'b0;
        while (!done && cyc < maxcyc) begin
            step(p, d, g, b);
            if (p) begin
                cap_g[cap_n] = g; cap_d[cap_n] = d; cap_c[cap_n] = cyc;
                cap_n++;
            end
            if (b && !prevb) begin
                gs[gs_n] = g; gap[gs_n] = gapc; gs_n++;
            end
            if (!b) gapc++; else gapc = 0;
            prevb = b;
            cyc++;
            done = all_empty() && !b;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL capture_timeout: got %0d cycles, limit %0d", cyc, maxcyc);
        end
    endtask

    // Transaction-level round robin with burst cap, from the current queues
    task automatic model_expect();
        int mrd [NR];
        int sel, cnt, k;
        bit found, lst;
        exp_n = 0;
        for (int i = 0; i < NR; i++) mrd[i] = rd[i];
        forever begin
            found = 1'b0; sel = 0;
            for (int i = 0; i < NR; i++) begin
                k = (m_ptr + i) % NR;
                if (!found && mrd[k] < wr[k]) begin
                    found = 1'b1; sel = k;
                end
            end
            if (!found) break;
            cnt = 0; lst = 1'b0;
            while (!lst && cnt < MB && mrd[sel] < wr[sel]) begin
                exp_g[exp_n] = sel[1:0];
                exp_d[exp_n] = mem[sel][mrd[sel]][7:0];
                lst = mem[sel][mrd[sel]][8];
                mrd[sel]++; cnt++; exp_n++;
            end
            m_ptr = (sel + 1) % NR;
        end
    endtask

    task automatic check_stream(input string name);
        n_vec++;
        if (cap_n !== exp_n) begin
            n_err++;
            $display("FAIL %s_len: got %0d expected %0d", name, cap_n, exp_n);
        end
        for (int i = 0; i < exp_n && i < cap_n; i++) begin
            n_vec++;
            if (cap_g[i] !== exp_g[i] || cap_d[i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL %s[%0d]: got gnt %0d dat %h expected gnt %0d dat %h",
                         name, i, cap_g[i], cap_d[i], exp_g[i], exp_d[i]);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; full = 1'b0; en = 1'b1; rand_full = 1'b0;
        for (int k = 0; k < NR; k++) begin rd[k] = 0; wr[k] = 0; end
        drive_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic check_idle_outputs(input string name);
        n_vec++;
        if (push !== 1'b0 || req_ready !== 4'b0 || dat !== 8'h00 || gnt !== 2'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got push %b ready %b dat %h gnt %0d busy %b expected all zero",
                     name, push, req_ready, dat, gnt, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; full = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_state");
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        add_byte(0, 8'h41, 0); add_byte(0, 8'h42, 0); add_byte(0, 8'h43, 1);
        run_capture(50, 0);
        n_vec++;
        if (cap_n !== 3) begin
            n_err++; $display("FAIL single_len: got %0d expected 3", cap_n);
        end
        for (int i = 0; i < 3 && i < cap_n; i++) begin
            n_vec++;
            if (cap_d[i] !== 8'h41 + 8'(i) || cap_g[i] !== 2'd0 || cap_c[i] !== i + 1) begin
                n_err++;
                $display("FAIL single_byte%0d: got dat %h gnt %0d cyc %0d expected dat %h gnt 0 cyc %0d",
                         i, cap_d[i], cap_g[i], cap_c[i], 8'h41 + 8'(i), i + 1);
            end
        end
        // Pointer moved past requester 0: requester 1 now wins
        add_byte(0, 8'h50, 1); add_byte(1, 8'h51, 1);
        run_capture(50, 0);
        n_vec++;
        if (gs_n < 1 || gs[0] !== 2'd1) begin
            n_err++; $display("FAIL single_ptr_adv: got first gnt %0d expected 1", gs[0]);
        end
    endtask

    task automatic test_rr();
        logic [1:0] order [4];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3; order[3] = 2'd0;
        do_reset();
        add_byte(0, 8'h00, 0); add_byte(0, 8'h01, 1);
        add_byte(0, 8'h02, 0); add_byte(0, 8'h03, 1);
        add_byte(1, 8'h10, 0); add_byte(1, 8'h11, 1);
        add_byte(3, 8'h30, 0); add_byte(3, 8'h31, 1);
        run_capture(100, 0);
        n_vec++;
        if (gs_n !== 4) begin
            n_err++; $display("FAIL rr_grants: got %0d expected 4", gs_n);
        end
        for (int i = 0; i < 4 && i < gs_n; i++) begin
            n_vec++;
            if (gs[i] !== order[i]) begin
                n_err++; $display("FAIL rr_order%0d: got %0d expected %0d", i, gs[i], order[i]);
            end
            if (i > 0) begin
                n_vec++;
                if (gap[i] !== 1) begin
                    n_err++; $display("FAIL rr_bubble%0d: got %0d idle cycles expected 1", i, gap[i]);
                end
            end
        end
    endtask

    task automatic test_burst();
        bit p, b;
        logic [7:0] d;
        logic [1:0] g;
        do_reset();
        for (int i = 0; i < 10; i++) add_byte(2, 8'h20 + 8'(i), i == 9);
        step(p, d, g, b);               // arbitration cycle, requester 2 alone
        add_byte(0, 8'hA0, 0); add_byte(0, 8'hA1, 1);
        exp_n = 0;
        for (int i = 0; i < 4; i++) begin exp_g[exp_n] = 2; exp_d[exp_n] = 8'h20 + 8'(i); exp_n++; end
        exp_g[exp_n] = 0; exp_d[exp_n] = 8'hA0; exp_n++;
        exp_g[exp_n] = 0; exp_d[exp_n] = 8'hA1; exp_n++;
        for (int i = 4; i < 10; i++) begin exp_g[exp_n] = 2; exp_d[exp_n] = 8'h20 + 8'(i); exp_n++; end
        run_capture(100, 1);
        check_stream("burst");
    endtask

    task automatic test_full();
        bit p, b;
        logic [7:0] d;
        logic [1:0] g;
        int npush;
        do_reset();
        for (int i = 0; i < 4; i++) add_byte(1, 8'hC0 + 8'(i), i == 3);
        npush = 0;
        for (int i = 0; i < 3; i++) begin
            step(p, d, g, b);
            if (p) npush++;
        end
        n_vec++;
        if (npush !== 2) begin
            n_err++; $display("FAIL full_pre: got %0d pushes expected 2", npush);
        end
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(p, d, g, b);
            n_vec++;
            if (p !== 1'b0 || b !== 1'b1) begin
                n_err++; $display("FAIL full_hold%0d: got push %b busy %b expected 0 1", i, p, b);
            end
        end
        full = 1'b0;
        exp_n = 2;
        exp_g[0] = 1; exp_d[0] = 8'hC2;
        exp_g[1] = 1; exp_d[1] = 8'hC3;
        run_capture(50, 1);
        check_stream("full");
        n_vec++;
        if (gs_n !== 0) begin
            n_err++; $display("FAIL full_regrant: got %0d new grants expected 0", gs_n);
        end
    endtask

    task automatic test_wrap();
        bit p, b;
        logic [7:0] d;
        logic [1:0] g;
        do_reset();
        add_byte(2, 8'h22, 1);
        run_capture(50, 0);
        add_byte(0, 8'h00, 1); add_byte(3, 8'h33, 1);
        run_capture(50, 0);
        n_vec++;
        if (gs_n !== 2 || gs[0] !== 2'd3 || gs[1] !== 2'd0) begin
            n_err++; $display("FAIL wrap_order: got n %0d first %0d second %0d expected 2 3 0",
                              gs_n, gs[0], gs[1]);
        end
        en = 1'b0;
        for (int k = 0; k < NR; k++) add_byte(k, 8'hE0 + 8'(k), 1);
        for (int i = 0; i < 10; i++) begin
            step(p, d, g, b);
            n_vec++;
            if (b !== 1'b0 || p !== 1'b0) begin
                n_err++; $display("FAIL en_low%0d: got busy %b push %b expected 0 0", i, b, p);
            end
        end
        en = 1'b1;
        m_ptr = 1;
        model_expect();
        run_capture(100, 0);
        check_stream("en_resume");
    endtask

    task automatic test_reset_mid();
        bit p, b;
        logic [7:0] d;
        logic [1:0] g;
        int npush, guard;
        do_reset();
        add_byte(0, 8'h55, 1);
        run_capture(50, 0);
        for (int i = 0; i < 6; i++) add_byte(1, 8'h61 + 8'(i), i == 5);
        npush = 0; guard = 0;
        while (npush < 3 && guard < 20) begin
            step(p, d, g, b);
            if (p) npush++;
            guard++;
        end
        n_vec++;
        if (npush !== 3) begin
            n_err++; $display("FAIL rstmid_pre: got %0d pushes expected 3", npush);
        end
        rst_n = 1'b0; full = 1'b1;
        step(p, d, g, b);
        @(negedge clk);
        #1;
        check_idle_outputs("rstmid_outputs");
        add_byte(0, 8'h77, 1);
        full = 1'b0;
        step(p, d, g, b);
        rst_n = 1'b1;
        exp_n = 4;
        exp_g[0] = 0; exp_d[0] = 8'h77;
        exp_g[1] = 1; exp_d[1] = 8'h64;
        exp_g[2] = 1; exp_d[2] = 8'h65;
        exp_g[3] = 1; exp_d[3] = 8'h66;
        run_capture(100, 0);
        check_stream("rstmid");
    endtask

    task automatic test_random();
        int npk, len;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NR; k++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 7);
                    for (int i = 0; i < len; i++) add_byte(k, 8'($urandom), i == len - 1);
                end
            end
            model_expect();
            rand_full = 1'b1;
            run_capture(2000, 0);
            rand_full = 1'b0;
            full = 1'b0;
            check_stream("random");
            for (int k = 0; k < NR; k++) begin rd[k] = 0; wr[k] = 0; end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_burst();
        test_full();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
